sc_microsequencer: RTL

- Parametrised microprogram sequencer for the ARC control unit. It generalises the fixed next / decode / jump micro-address selection.
- Holds the registered micro-PC (uPC) and the processor status flags register.
- Adds a configurable-depth microcode return stack (CALL/RETURN), a stall input and a full set of branch conditions.
- Sits between the MIR (which supplies the sequence fields) and the control store (which receives the address).

---
 rtl/sc_microseq_pkg.sv | 38 +++
 rtl/sc_microseq_stack.sv | 49 ++++
 rtl/sc_microsequencer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/sc_microseq_pkg.sv
// Shared encodings and helpers for the ARC microprogram sequencer.
// Covers sequence ops, condition selects, PSR flag positions and DECODE address construction.
package sc_microseq_pkg;

  typedef enum logic [2:0] {
    SEQ_NEXT   = 3'd0,
    SEQ_BRANCH = 3'd1,
    SEQ_DECODE = 3'd2,
    SEQ_CALL   = 3'd3,
    SEQ_RETURN = 3'd4
  } seq_op_e;

  typedef enum logic [2:0] {
    COND_ALWAYS = 3'd0,
    COND_N      = 3'd1,
    COND_Z      = 3'd2,
    COND_V      = 3'd3,
    COND_C      = 3'd4,
    COND_IR13   = 3'd5,
    COND_NOTZ   = 3'd6,
    COND_NEVER  = 3'd7
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

  // DECODE target: MSB set, opcode shifted left by two, zeros in between.
  function automatic logic [31:0] dec_addr(input logic [31:0] op,
                                           input int unsigned op_w,
                                           input int unsigned addr_w);
    logic [31:0] mask;
    mask = (32'd1 << op_w) - 32'd1;
    return (32'd1 << (addr_w - 1)) | ((op & mask) << 2);
  endfunction

endpackage

// File: rtl/sc_microseq_stack.sv
// Microcode return-address LIFO, indexed by its occupancy count.
// The caller guarantees push is never asserted when full nor pop when empty.
module sc_microseq_stack
  import sc_microseq_pkg::*;
#(
  parameter int ADDR_W      = 11,
  parameter int STACK_DEPTH = 4,
  parameter int SP_W        = 3
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [ADDR_W-1:0] i_data,
  output logic [ADDR_W-1:0] o_top,
  output logic [SP_W-1:0]   o_count,
  output logic              o_full,
  output logic              o_empty
);

  logic [ADDR_W-1:0] r_mem [STACK_DEPTH];
  logic [SP_W-1:0]   r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        if (i_push && r_count == SP_W'(i)) r_mem[i] <= i_data;
      end
      if (i_push)     r_count <= r_count + SP_W'(1);
      else if (i_pop) r_count <= r_count - SP_W'(1);
    end
  end

  // Top of stack lives one slot below the count.
  always_comb begin
    o_top = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (r_count == SP_W'(i + 1)) o_top = r_mem[i];
    end
  end

  assign o_count = r_count;
  assign o_full  = (r_count == SP_W'(STACK_DEPTH));
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/sc_microsequencer.sv
// ARC microprogram sequencer: registered uPC, PSR, branch condition mux,
// next-address selection with CALL/RETURN via a return stack, sticky stack errors.
module sc_microsequencer
  import sc_microseq_pkg::*;
#(
  parameter int ADDR_W      = 11,
  parameter int OP_W        = 8,
  parameter int COND_W      = 3,
  parameter int FLAGS_W     = 4,
  parameter int STACK_DEPTH = 4,
  parameter int SP_W        = 3
) (
  input  logic               SC_MicroSeq_CLOCK_50,
  input  logic               SC_MicroSeq_RESET_InLow,
  input  logic               SC_MicroSeq_Stall_InHigh,
  input  logic [2:0]         SC_MicroSeq_SeqOp_In,
  input  logic [COND_W-1:0]  SC_MicroSeq_Cond_In,
  input  logic [ADDR_W-1:0]  SC_MicroSeq_JumpAddr_In,
  input  logic [OP_W-1:0]    SC_MicroSeq_IR_OP_In,
  input  logic               SC_MicroSeq_IR13_In,
  input  logic [FLAGS_W-1:0] SC_MicroSeq_Flags_In,
  input  logic               SC_MicroSeq_FlagsWrite_InHigh,
  input  logic               SC_MicroSeq_ErrClear_InHigh,
  output logic [ADDR_W-1:0]  SC_MicroSeq_Addr_Out,
  output logic [FLAGS_W-1:0] SC_MicroSeq_Psr_Out,
  output logic [SP_W-1:0]    SC_MicroSeq_StackCount_Out,
  output logic               SC_MicroSeq_Overflow_Out,
  output logic               SC_MicroSeq_Underflow_Out
);

  logic [ADDR_W-1:0]  r_upc;
  logic [FLAGS_W-1:0] r_psr;
  logic               r_ovf, r_unf;

  logic [ADDR_W-1:0]  w_inc, w_dec, w_next, w_top;
  logic               w_cond, w_push, w_pop, w_full, w_empty;
  logic               w_ovf_set, w_unf_set;

  assign w_inc = r_upc + ADDR_W'(1);
  assign w_dec = ADDR_W'(dec_addr(32'(SC_MicroSeq_IR_OP_In), OP_W, ADDR_W));

  // Conditions look at the registered PSR, so a same-cycle flags write is not seen.
  always_comb begin
    w_cond = 1'b0;
    case (SC_MicroSeq_Cond_In)
      COND_W'(COND_ALWAYS): w_cond = 1'b1;
      COND_W'(COND_N):      w_cond = r_psr[FLAG_N];
      COND_W'(COND_Z):      w_cond = r_psr[FLAG_Z];
      COND_W'(COND_V):      w_cond = r_psr[FLAG_V];
      COND_W'(COND_C):      w_cond = r_psr[FLAG_C];
      COND_W'(COND_IR13):   w_cond = SC_MicroSeq_IR13_In;
      COND_W'(COND_NOTZ):   w_cond = ~r_psr[FLAG_Z];
      default:              w_cond = 1'b0;
    endcase
  end

  always_comb begin
    w_next    = r_upc;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_ovf_set = 1'b0;
    w_unf_set = 1'b0;
    if (!SC_MicroSeq_Stall_InHigh) begin
      w_next = w_inc;
      case (SC_MicroSeq_SeqOp_In)
        SEQ_BRANCH: if (w_cond) w_next = SC_MicroSeq_JumpAddr_In;
        SEQ_DECODE: w_next = w_dec;
        SEQ_CALL: begin
          if (w_cond && !w_full) begin
            w_push = 1'b1;
            w_next = SC_MicroSeq_JumpAddr_In;
          end else if (w_cond) begin
            w_ovf_set = 1'b1;
          end
        end
        SEQ_RETURN: begin
          if (!w_empty) begin
            w_pop  = 1'b1;
            w_next = w_top;
          end else begin
            w_next    = '0;
            w_unf_set = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge SC_MicroSeq_CLOCK_50 or negedge SC_MicroSeq_RESET_InLow) begin
    if (!SC_MicroSeq_RESET_InLow) begin
      r_upc <= '0;
      r_psr <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_upc <= w_next;
      if (SC_MicroSeq_FlagsWrite_InHigh) r_psr <= SC_MicroSeq_Flags_In;
      // A new error outranks a simultaneous clear.
      r_ovf <= w_ovf_set | (r_ovf & ~SC_MicroSeq_ErrClear_InHigh);
      r_unf <= w_unf_set | (r_unf & ~SC_MicroSeq_ErrClear_InHigh);
    end
  end

  sc_microseq_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH),
    .SP_W        (SP_W)
  ) u_stack (
    .i_clk   (SC_MicroSeq_CLOCK_50),
    .i_rst_n (SC_MicroSeq_RESET_InLow),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_inc),
    .o_top   (w_top),
    .o_count (SC_MicroSeq_StackCount_Out),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign SC_MicroSeq_Addr_Out      = r_upc;
  assign SC_MicroSeq_Psr_Out       = r_psr;
  assign SC_MicroSeq_Overflow_Out  = r_ovf;
  assign SC_MicroSeq_Underflow_Out = r_unf;

endmodule
